// File: rtl/adder_sweep_pkg.sv
// Shared types and width helpers for the approximate-adder sweep controller.
package adder_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_N_IN = 4;
  localparam int unsigned DEF_ET   = 4;

  // Operand width: each operand takes half of the adder inputs.
  function automatic int unsigned op_width(input int unsigned n_in);
    return n_in / 2;
  endfunction

  // Error-count width: wide enough to count all 2^n_in vectors without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/adder_exact_ref.sv
// Golden exact adder: splits the stimulus vector into A (low half) and B (high half).
module adder_exact_ref
  import adder_sweep_pkg::*;
#(
  parameter int unsigned N_IN = DEF_N_IN
) (
  input  logic [N_IN-1:0]   vec,
  output logic [N_IN/2:0]   sum_c
);

  localparam int unsigned OP_W  = op_width(N_IN);
  localparam int unsigned SUM_W = OP_W + 1;

  assign sum_c = SUM_W'(vec[OP_W-1:0]) + SUM_W'(vec[N_IN-1:OP_W]);

endmodule

// File: rtl/adder_et_sweep_ctrl.sv
// Exhaustive error characterisation of an approximate adder against its exact sum.
// Optional ADDER_SWEEP_EARLY_EXIT_EN: stop at the first vector whose error exceeds ET.
module adder_et_sweep_ctrl
  import adder_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = DEF_N_IN,
  parameter int unsigned N_OUT = DEF_N_IN / 2 + 1,
  parameter int unsigned ET    = DEF_ET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       dut_in,
  input  logic [N_OUT-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_IN:0]         err_count,
  output logic [N_IN-1:0]       worst_vec
);

  localparam int unsigned CNT_W  = cnt_width(N_IN);
  localparam int unsigned DIFF_W = N_OUT + 1;

  state_t             state, state_nx;
  logic [N_IN-1:0]    dut_in_nx;
  logic               busy_nx, done_nx, pass_nx;
  logic [N_OUT-1:0]   max_err_nx;
  logic [CNT_W-1:0]   err_count_nx;
  logic [N_IN-1:0]    worst_vec_nx;

  logic [N_OUT-1:0]   exact_c;
  logic [DIFF_W-1:0]  diff_c;
  logic [N_OUT-1:0]   err_c;
  logic               last_vec_c;
  logic               early_fail_c;

  adder_exact_ref #(.N_IN(N_IN)) u_exact (
    .vec   (dut_in),
    .sum_c (exact_c)
  );

  // Signed difference in one extra bit; magnitude always fits back in N_OUT bits.
  assign diff_c     = DIFF_W'(exact_c) - DIFF_W'(dut_out);
  assign err_c      = diff_c[N_OUT] ? N_OUT'(-diff_c) : N_OUT'(diff_c);
  assign last_vec_c = (dut_in == '1);

`ifdef ADDER_SWEEP_EARLY_EXIT_EN
  assign early_fail_c = (32'(err_c) > ET);
`else
  assign early_fail_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    dut_in_nx    = dut_in;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    pass_nx      = pass;
    max_err_nx   = max_err;
    err_count_nx = err_count;
    worst_vec_nx = worst_vec;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx     = SWEEP;
          busy_nx      = 1'b1;
          dut_in_nx    = '0;
          pass_nx      = 1'b0;
          max_err_nx   = '0;
          err_count_nx = '0;
          worst_vec_nx = '0;
        end
      end
      SWEEP: begin
        if (err_c != '0) err_count_nx = err_count + CNT_W'(1);
        // Strict compare keeps the first vector that reaches a new maximum.
        if (err_c > max_err) begin
          max_err_nx   = err_c;
          worst_vec_nx = dut_in;
        end
        if (last_vec_c || early_fail_c) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          pass_nx  = (32'(max_err_nx) <= ET);
        end else begin
          dut_in_nx = dut_in + N_IN'(1);
          busy_nx   = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      max_err   <= '0;
      err_count <= '0;
      worst_vec <= '0;
    end else begin
      dut_in    <= dut_in_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      max_err   <= max_err_nx;
      err_count <= err_count_nx;
      worst_vec <= worst_vec_nx;
    end
  end

endmodule

// File: tb/tb_adder_et_sweep_ctrl.sv
// Directed bench for adder_et_sweep_ctrl with a switchable approximate-adder model.
module tb_adder_et_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dut_in;
  logic [2:0] dut_out;
  logic       busy, done, pass;
  logic [2:0] max_err;
  logic [4:0] err_count;
  logic [3:0] worst_vec;

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;
  int done_at, busy_cnt, done_cnt;

  adder_et_sweep_ctrl #(.N_IN(4), .N_OUT(3), .ET(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .max_err   (max_err),
    .err_count (err_count),
    .worst_vec (worst_vec)
  );

  always #5 clk = ~clk;

  // Approximate adder model: 0 exact, 1 tied to zero, 2/3 exact except vector 5.
  always_comb begin
    logic [2:0] ex;
    ex = 3'(dut_in[1:0]) + 3'(dut_in[3:2]);
    case (mode)
      1:       dut_out = 3'd0;
      2:       dut_out = (dut_in == 4'h5) ? 3'd6 : ex;
      3:       dut_out = (dut_in == 4'h5) ? 3'd7 : ex;
      default: dut_out = ex;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse or hold start, then watch a fixed 22-cycle window from the start edge.
  task automatic run_sweep(input bit hold, output int d_at, output int b_cnt, output int d_cnt);
    d_at = 0; b_cnt = 0; d_cnt = 0;
    start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (!hold) start = 1'b0;
      if (busy) b_cnt++;
      if (done) begin
        d_cnt++;
        if (d_at == 0) d_at = k;
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_dut_in", 32'(dut_in), 0);
    chk("rst_max_err", 32'(max_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_worst_vec", 32'(worst_vec), 0);
    rst = 1'b0;
    step();

    // Exact adder as DUT.
    mode = 0;
    run_sweep(1'b0, done_at, busy_cnt, done_cnt);
    chk("exact_done_at", 32'(done_at), 17);
    chk("exact_busy_cnt", 32'(busy_cnt), 16);
    chk("exact_done_cnt", 32'(done_cnt), 1);
    chk("exact_max_err", 32'(max_err), 0);
    chk("exact_err_count", 32'(err_count), 0);
    chk("exact_worst_vec", 32'(worst_vec), 0);
    chk("exact_pass", 32'(pass), 1);

    // Tied-to-zero DUT: error is A+B, worst at A=B=3.
    mode = 1;
    run_sweep(1'b0, done_at, busy_cnt, done_cnt);
    chk("zero_done_at", 32'(done_at), 17);
    chk("zero_max_err", 32'(max_err), 6);
    chk("zero_err_count", 32'(err_count), 15);
    chk("zero_worst_vec", 32'(worst_vec), 32'h0F);
    chk("zero_pass", 32'(pass), 0);

    // Vector 5 off by 4: exactly at ET.
    mode = 2;
    run_sweep(1'b0, done_at, busy_cnt, done_cnt);
    chk("et_eq_done_at", 32'(done_at), 17);
    chk("et_eq_max_err", 32'(max_err), 4);
    chk("et_eq_err_count", 32'(err_count), 1);
    chk("et_eq_worst_vec", 32'(worst_vec), 5);
    chk("et_eq_pass", 32'(pass), 1);

    // Vector 5 off by 5: one above ET.
    mode = 3;
    run_sweep(1'b0, done_at, busy_cnt, done_cnt);
`ifdef ADDER_SWEEP_EARLY_EXIT_EN
    chk("et_gt_done_at", 32'(done_at), 7);
    chk("et_gt_busy_cnt", 32'(busy_cnt), 6);
`else
    chk("et_gt_done_at", 32'(done_at), 17);
    chk("et_gt_busy_cnt", 32'(busy_cnt), 16);
`endif
    chk("et_gt_done_cnt", 32'(done_cnt), 1);
    chk("et_gt_max_err", 32'(max_err), 5);
    chk("et_gt_err_count", 32'(err_count), 1);
    chk("et_gt_worst_vec", 32'(worst_vec), 5);
    chk("et_gt_pass", 32'(pass), 0);

    // Start held through the sweep, dropped in the done cycle.
    mode = 0;
    run_sweep(1'b1, done_at, busy_cnt, done_cnt);
    chk("hold_done_at", 32'(done_at), 17);
    chk("hold_busy_cnt", 32'(busy_cnt), 16);
    chk("hold_done_cnt", 32'(done_cnt), 1);
    chk("hold_pass", 32'(pass), 1);

    // Start still high in IDLE after done launches a new sweep.
    start = 1'b1;
    done_at = 0;
    for (int k = 1; k <= 30 && done_at == 0; k++) begin
      step();
      if (done) done_at = k;
    end
    chk("restart_done_at", 32'(done_at), 17);
    step();
    chk("restart_idle_busy", 32'(busy), 0);
    step();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_dut_in", 32'(dut_in), 0);
    repeat (20) step();

    // Reset in the 8th sweep cycle.
    mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("mid_busy_before", 32'(busy), 1);
    chk("mid_dut_in_before", 32'(dut_in), 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_pass", 32'(pass), 0);
    chk("mid_rst_dut_in", 32'(dut_in), 0);
    chk("mid_rst_max_err", 32'(max_err), 0);
    chk("mid_rst_err_count", 32'(err_count), 0);
    chk("mid_rst_worst_vec", 32'(worst_vec), 0);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done || busy) done_cnt++;
    end
    chk("mid_rst_quiet", 32'(done_cnt), 0);

    run_sweep(1'b0, done_at, busy_cnt, done_cnt);
    chk("post_rst_done_at", 32'(done_at), 17);
    chk("post_rst_max_err", 32'(max_err), 6);
    chk("post_rst_err_count", 32'(err_count), 15);
    chk("post_rst_worst_vec", 32'(worst_vec), 32'h0F);
    chk("post_rst_pass", 32'(pass), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_et_sweep_ctrl.md
# adder_et_sweep_ctrl

Sequencing controller that exhaustively characterises one approximate adder netlist (N_IN inputs, N_OUT outputs) against its exact equivalent. On a start request it drives every input vector in ascending order into the combinational approximate adder and compares each response with an internal exact sum. It accumulates the worst-case absolute error, the number of erroneous vectors and the worst vector, then reports pass/fail against the error threshold ET. It sits beside the approximate-adder instance in the characterisation wrapper; the adder's inputs are driven only by this block.

## Interface
- N_IN, 4, adder input count; operand A = dut_in[N_IN/2-1:0], operand B = dut_in[N_IN-1:N_IN/2]; must be even, ≥2
- N_OUT, 3, adder output count; equals N_IN/2+1
- ET, 4, maximum tolerated absolute error (unsigned)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- dut_in  out  N_IN  registered stimulus to approximate adder (bit i → in<i>)
- dut_out  in  N_OUT  combinational response of approximate adder (bit j ← out<j>)
- busy  out  1  high for every SWEEP cycle
- done  out  1  one-cycle pulse when results become valid
- pass  out  1  max_err ≤ ET; valid from done until next start
- max_err  out  N_OUT  largest |exact − approx| seen
- err_count  out  N_IN+1  vectors with nonzero error
- worst_vec  out  N_IN  first vector reaching max_err

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE: start=1 → clear max_err, err_count, worst_vec and pass; set dut_in=0; go to SWEEP. Otherwise outputs hold.
- SWEEP, every cycle:
  - exact = A + B, zero-extended to N_OUT bits.
  - err = |exact − dut_out|, computed in N_OUT+1 bits with a sign check and truncated to N_OUT. The result cannot overflow because both values are < 2^N_OUT.
  - If err ≠ 0: err_count += 1.
  - If err > max_err: max_err ← err and worst_vec ← dut_in. Strict comparison, so the first occurrence wins on ties.
  - If dut_in = all-ones: go to DONE. Otherwise dut_in += 1.
- DONE: done=1 and pass = (final max_err ≤ ET). Accumulators already include the last vector. Return to IDLE next cycle.
- start while busy or in DONE: ignored.
- rst at any cycle, including mid-sweep: immediate return to IDLE. The partial sweep is discarded and no done pulse is issued.

## Timing
- Reset values: state IDLE; dut_in 0; busy 0; done 0; pass 0; max_err 0; err_count 0; worst_vec 0.
- dut_out is sampled in the same cycle its dut_in is presented. The DUT is combinational and dut_in is a register, so it is stable for the whole cycle.
- start high at edge t:
  - busy=1 from cycle t+1 through t+2^N_IN.
  - done=1 in cycle t+2^N_IN+1.
  - Default parameters: 16 SWEEP cycles, done at t+17.
- A fresh start is accepted in the cycle after done, i.e. back in IDLE.
- err_count does not wrap: N_IN+1 bits covers 2^N_IN vectors.

## Configuration
- ADDER_SWEEP_EARLY_EXIT_EN defined:
  - In SWEEP, the first vector with err > ET updates the accumulators normally and then goes directly to DONE with pass=0.
  - worst_vec holds that failing vector.
  - busy length is (failing vector index + 1).
- Undefined: the full 2^N_IN-vector sweep always runs; pass is evaluated only at the end.

## Structure
- Package adder_sweep_pkg holds:
  - the state enum (IDLE, SWEEP, DONE);
  - width helper constants for operand width N_IN/2 and count width N_IN+1;
  - the default ET.
- One sub-module, adder_exact_ref: combinational, parameterised on N_IN. It takes dut_in and returns the exact N_OUT-bit sum. The controller instantiates it to keep the golden model separately testable.

## Test plan
- Exact adder connected as the DUT, start pulse → 16 busy cycles, done at t+17, max_err=0, err_count=0, worst_vec=0, pass=1.
- DUT tied to 0 → max_err=6, worst_vec=4'hF, err_count=15, pass=0.
- DUT = exact except vector 4'h5 (A=1, B=1) returns 6 → max_err=4, err_count=1, worst_vec=4'h5, pass=1 (ET=4 boundary).
- Same test, but vector 4'h5 returns 7 → max_err=5, pass=0.
  - Macro defined: done in cycle t+7, busy for 6 cycles, worst_vec=4'h5.
  - Macro undefined: done at t+17.
- start held high through the whole sweep → exactly one sweep runs and exactly one done pulse is issued. A new sweep starts only if start is still high in IDLE after done.
- rst asserted in the 8th SWEEP cycle → next cycle all outputs are at reset values and no done pulse appears. A subsequent start yields the full correct result.
